preparser_golden_checker: RTL and testbench
===========================================

# preparser_golden_checker

Parametrised, loadable golden-vector checker for the preparser output stream. A table of up to DEPTH expected beats (data, token_pos, address, garbage, start_lit), each with a per-bit compare mask, is written at run time. Each valid beat is compared in order, and pass/fail is reported with the failing index, the mismatching fields and an overrun indication. It sits beside the preparser in simulation and FPGA debug builds, replacing hard-coded per-testcase checkers.

## Interface
- DATA_W, 144, width of data_out
- TOKEN_W, 16, width of token_pos
- ADDR_W, 17, width of address
- GARB_W, 3, width of garbage
- DEPTH, 16, number of golden entries (≥2)
- IDX_W, $clog2(DEPTH), entry index width
- REC_W (local), DATA_W+TOKEN_W+ADDR_W+GARB_W+1; record packing MSB→LSB: data, token_pos, address, garbage, start_lit
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous active-high reset
- data_out  in  DATA_W  observed beat data
- token_pos  in  TOKEN_W  observed token positions
- address  in  ADDR_W  observed address
- garbage  in  GARB_W  observed garbage count
- start_lit  in  1  observed start-literal flag
- valid  in  1  observed beat qualifier
- gold_we  in  1  golden table write strobe
- gold_waddr  in  IDX_W  golden entry index
- gold_wdata  in  REC_W  expected record
- gold_wmask  in  REC_W  compare mask, 1 = compare bit
- cfg_count  in  IDX_W+1  number of entries to check
- start  in  1  arm checking (pulse)
- clear  in  1  return to IDLE (pulse)
- status  out  2  0 IDLE, 1 RUN, 2 PASS, 3 FAIL
- cur_idx  out  IDX_W  next entry expected
- fail_idx  out  IDX_W  entry at which failure occurred
- fail_fields  out  5  mismatching fields {data, token, addr, garbage, start_lit}
- overrun  out  1  valid beat seen after PASS
- beat_cnt  out  16  valid beats seen since start, saturating at 16'hFFFF

## Operation
- Golden table: DEPTH×REC_W value array plus DEPTH×REC_W mask array. Not reset; contents are retained across clear. Written only in IDLE; writes in other states are ignored.
- Effective count N = min(cfg_count, DEPTH), sampled on start.
- Beat match: ((observed ^ gold[cur_idx]) & mask[cur_idx]) == 0 for all bits.
- fail_fields bit = OR of masked mismatches within that field.
- IDLE: start with N=0 → PASS. Start with N>0 → RUN, cur_idx=0, beat_cnt=0, fail_*=0, overrun=0.
- RUN, valid, match:
  - cur_idx==N-1 → PASS.
  - Otherwise cur_idx+1.
- RUN, valid, mismatch → FAIL; latch fail_idx=cur_idx and fail_fields. cur_idx holds.
- RUN, no valid: hold.
- PASS, valid → FAIL, overrun=1, fail_idx=cur_idx, fail_fields=0.
- FAIL: sticky until clear or rst. Further valid only increments beat_cnt.
- beat_cnt increments on every valid outside IDLE.
- start outside IDLE is ignored.
- clear from any state → IDLE; status, cur_idx, fail_*, overrun and beat_cnt are zeroed.
- clear and start in the same cycle: clear wins.
- clear and valid in the same cycle: the beat is ignored.

## Timing
- rst asserted: all outputs 0 immediately (asynchronous), status=IDLE. Release is synchronous to clk.
- Compare is combinational against the asynchronous table read. All results are registered.
- status, cur_idx, fail_* and beat_cnt reflect beat k on the clock edge that samples it (1-cycle latency). Back-to-back valid beats are supported at full rate.
- A table write on edge t is visible to a start on edge t+1.
- start→RUN takes 1 cycle. A valid in the same cycle as start is not checked.
- rst mid-RUN aborts the run. The table is retained (rst does not touch table storage).

## Test plan
- Load entry0 = {144'h040d0a090200203a01007c414c4943000000, 16'h9520, 17'h0, 3'h3, 0}, full mask; cfg_count=1; start; drive that beat → status=2, beat_cnt=1.
- Load 7 entries, cfg_count=7; drive 7 matching back-to-back beats → cur_idx 0..6 then PASS. An 8th valid → status=3, overrun=1, fail_idx=6, fail_fields=0.
- Load 4 entries; beat 2 has address 17'h0002b instead of 17'h0002a → status=3, fail_idx=2, fail_fields=5'b00100. Later beats leave fail_* unchanged.
- Mask entry0 garbage field to 0; drive garbage=3'h7 with other fields matching → match, cur_idx=1.
- cfg_count=0 then start → PASS next cycle. cfg_count=31 with DEPTH=16 → PASS after 16 beats.
- Assert rst mid-RUN → status=0 and all outputs 0 without a clock edge. Restart and replay the beats → PASS with the same table contents. clear+start in the same cycle → IDLE.

Source files
------------

// File: rtl/preparser_golden_checker.sv
// Loadable golden-vector checker for the preparser output stream.
// A run-time table of expected records and per-bit compare masks is walked
// in order, one entry per valid beat. Status, failing index, mismatching
// fields and an overrun flag are reported.
module preparser_golden_checker #(
  parameter  int DATA_W  = 144,
  parameter  int TOKEN_W = 16,
  parameter  int ADDR_W  = 17,
  parameter  int GARB_W  = 3,
  parameter  int DEPTH   = 16,
  parameter  int IDX_W   = $clog2(DEPTH),
  localparam int REC_W   = DATA_W + TOKEN_W + ADDR_W + GARB_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  data_out,
  input  logic [TOKEN_W-1:0] token_pos,
  input  logic [ADDR_W-1:0]  address,
  input  logic [GARB_W-1:0]  garbage,
  input  logic               start_lit,
  input  logic               valid,
  input  logic               gold_we,
  input  logic [IDX_W-1:0]   gold_waddr,
  input  logic [REC_W-1:0]   gold_wdata,
  input  logic [REC_W-1:0]   gold_wmask,
  input  logic [IDX_W:0]     cfg_count,
  input  logic               start,
  input  logic               clear,
  output logic [1:0]         status,
  output logic [IDX_W-1:0]   cur_idx,
  output logic [IDX_W-1:0]   fail_idx,
  output logic [4:0]         fail_fields,
  output logic               overrun,
  output logic [15:0]        beat_cnt
);

  // Bit positions of each field inside a packed record (LSB first).
  localparam int GARB_LSB = 1;
  localparam int ADDR_LSB = GARB_LSB + GARB_W;
  localparam int TOK_LSB  = ADDR_LSB + ADDR_W;
  localparam int DATA_LSB = TOK_LSB + TOKEN_W;

  localparam logic [IDX_W:0] CNT_DEPTH = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] CNT_ONE   = (IDX_W+1)'(1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPass = 2'd2,
    StFail = 2'd3
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [REC_W-1:0]   r_goldVal  [DEPTH];
  logic [REC_W-1:0]   r_goldMask [DEPTH];

  logic [IDX_W:0]     r_count;
  logic [IDX_W-1:0]   r_curIdx;
  logic [IDX_W-1:0]   r_failIdx;
  logic [4:0]         r_failFields;
  logic               r_overrun;
  logic [15:0]        r_beatCnt;

  logic [IDX_W:0]     w_countNext;
  logic [IDX_W-1:0]   w_curIdxNext;
  logic [IDX_W-1:0]   w_failIdxNext;
  logic [4:0]         w_failFieldsNext;
  logic               w_overrunNext;
  logic [15:0]        w_beatCntNext;

  logic [REC_W-1:0]   w_observed;
  logic [REC_W-1:0]   w_diff;
  logic [4:0]         w_fields;
  logic               w_match;
  logic               w_isLast;
  logic [IDX_W:0]     w_effCount;
  logic [15:0]        w_beatSat;

  // Golden table: no reset, so contents survive both clear and rst.
  always_ff @(posedge clk) begin
    if (gold_we && (r_state == StIdle) && (int'(gold_waddr) < DEPTH)) begin
      r_goldVal[gold_waddr]  <= gold_wdata;
      r_goldMask[gold_waddr] <= gold_wmask;
    end
  end

  assign w_observed = {data_out, token_pos, address, garbage, start_lit};
  assign w_diff     = (w_observed ^ r_goldVal[r_curIdx]) & r_goldMask[r_curIdx];
  assign w_fields   = {|w_diff[DATA_LSB +: DATA_W], |w_diff[TOK_LSB +: TOKEN_W],
                       |w_diff[ADDR_LSB +: ADDR_W], |w_diff[GARB_LSB +: GARB_W],
                       w_diff[0]};
  assign w_match    = (w_diff == '0);
  assign w_isLast   = ({1'b0, r_curIdx} == (r_count - CNT_ONE));
  assign w_effCount = (cfg_count > CNT_DEPTH) ? CNT_DEPTH : cfg_count;
  assign w_beatSat  = (r_beatCnt == 16'hFFFF) ? r_beatCnt : (r_beatCnt + 16'd1);

  // State and result registers; rst clears everything except the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_count      <= '0;
      r_curIdx     <= '0;
      r_failIdx    <= '0;
      r_failFields <= '0;
      r_overrun    <= 1'b0;
      r_beatCnt    <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_count      <= w_countNext;
      r_curIdx     <= w_curIdxNext;
      r_failIdx    <= w_failIdxNext;
      r_failFields <= w_failFieldsNext;
      r_overrun    <= w_overrunNext;
      r_beatCnt    <= w_beatCntNext;
    end
  end

  // Next-state and result logic; clear takes priority over start and valid.
  always_comb begin
    w_stateNext      = r_state;
    w_countNext      = r_count;
    w_curIdxNext     = r_curIdx;
    w_failIdxNext    = r_failIdx;
    w_failFieldsNext = r_failFields;
    w_overrunNext    = r_overrun;
    w_beatCntNext    = r_beatCnt;
    if (clear) begin
      w_stateNext      = StIdle;
      w_countNext      = '0;
      w_curIdxNext     = '0;
      w_failIdxNext    = '0;
      w_failFieldsNext = '0;
      w_overrunNext    = 1'b0;
      w_beatCntNext    = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            w_countNext      = w_effCount;
            w_curIdxNext     = '0;
            w_failIdxNext    = '0;
            w_failFieldsNext = '0;
            w_overrunNext    = 1'b0;
            w_beatCntNext    = '0;
            w_stateNext      = (w_effCount == '0) ? StPass : StRun;
          end
        end
        StRun: begin
          if (valid) begin
            w_beatCntNext = w_beatSat;
            if (!w_match) begin
              w_stateNext      = StFail;
              w_failIdxNext    = r_curIdx;
              w_failFieldsNext = w_fields;
            end else if (w_isLast) begin
              w_stateNext = StPass;
            end else begin
              w_curIdxNext = r_curIdx + 1'b1;
            end
          end
        end
        StPass: begin
          if (valid) begin
            w_beatCntNext    = w_beatSat;
            w_stateNext      = StFail;
            w_overrunNext    = 1'b1;
            w_failIdxNext    = r_curIdx;
            w_failFieldsNext = '0;
          end
        end
        default: begin
          if (valid) begin
            w_beatCntNext = w_beatSat;
          end
        end
      endcase
    end
  end

  assign status      = r_state;
  assign cur_idx     = r_curIdx;
  assign fail_idx    = r_failIdx;
  assign fail_fields = r_failFields;
  assign overrun     = r_overrun;
  assign beat_cnt    = r_beatCnt;

endmodule

// File: tb/tb_preparser_golden_checker.sv
// Self-checking bench for preparser_golden_checker: directed scenarios plus
// a randomized phase, all checked against a behavioural model of the checker.
module tb_preparser_golden_checker;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [143:0] d;
    logic [15:0]  t;
    logic [16:0]  a;
    logic [2:0]   g;
    logic         s;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  rec_t        obs;
  logic        valid;
  logic        gold_we;
  logic [3:0]  gold_waddr;
  rec_t        gold_wdata;
  rec_t        gold_wmask;
  logic [4:0]  cfg_count;
  logic        start;
  logic        clear;
  logic [1:0]  status;
  logic [3:0]  cur_idx;
  logic [3:0]  fail_idx;
  logic [4:0]  fail_fields;
  logic        overrun;
  logic [15:0] beat_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  rec_t mGold [DEPTH];
  rec_t mMask [DEPTH];
  int   mStatus, mCur, mFailIdx, mFields, mOver, mBeat, mCount;

  rec_t fullMask;
  rec_t zeroRec;
  rec_t tbl [DEPTH];

  // Free-running clock.
  always #5 clk = ~clk;

  preparser_golden_checker dut (
    .clk         (clk),
    .rst         (rst),
    .data_out    (obs.d),
    .token_pos   (obs.t),
    .address     (obs.a),
    .garbage     (obs.g),
    .start_lit   (obs.s),
    .valid       (valid),
    .gold_we     (gold_we),
    .gold_waddr  (gold_waddr),
    .gold_wdata  (gold_wdata),
    .gold_wmask  (gold_wmask),
    .cfg_count   (cfg_count),
    .start       (start),
    .clear       (clear),
    .status      (status),
    .cur_idx     (cur_idx),
    .fail_idx    (fail_idx),
    .fail_fields (fail_fields),
    .overrun     (overrun),
    .beat_cnt    (beat_cnt)
  );

  function automatic rec_t randRec();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[180:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic modelReset();
    mStatus = 0; mCur = 0; mFailIdx = 0; mFields = 0; mOver = 0; mBeat = 0; mCount = 0;
  endtask

  // One clock edge of the checker's behaviour, using pre-edge inputs.
  task automatic modelEdge();
    int   prev;
    rec_t diff;
    prev = mStatus;
    if (gold_we && prev == 0) begin
      mGold[gold_waddr] = gold_wdata;
      mMask[gold_waddr] = gold_wmask;
    end
    diff = (obs ^ mGold[mCur]) & mMask[mCur];
    if (clear) begin
      modelReset();
    end else if (prev == 0) begin
      if (start) begin
        mCount = (cfg_count > DEPTH) ? DEPTH : int'(cfg_count);
        mCur = 0; mFailIdx = 0; mFields = 0; mOver = 0; mBeat = 0;
        mStatus = (mCount == 0) ? 2 : 1;
      end
    end else if (valid) begin
      if (mBeat < 65535) mBeat++;
      if (prev == 1) begin
        if (diff == '0) begin
          if (mCur == mCount - 1) mStatus = 2;
          else mCur++;
        end else begin
          mStatus  = 3;
          mFailIdx = mCur;
          mFields  = int'({|diff.d, |diff.t, |diff.a, |diff.g, diff.s});
        end
      end else if (prev == 2) begin
        mStatus = 3; mOver = 1; mFailIdx = mCur; mFields = 0;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("status",      32'(status),      32'(mStatus));
    checkOutput("cur_idx",     32'(cur_idx),     32'(mCur));
    checkOutput("fail_idx",    32'(fail_idx),    32'(mFailIdx));
    checkOutput("fail_fields", 32'(fail_fields), 32'(mFields));
    checkOutput("overrun",     32'(overrun),     32'(mOver));
    checkOutput("beat_cnt",    32'(beat_cnt),    32'(mBeat));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then check.
  task automatic applyStimulus(input logic st, input logic cl, input logic v, input rec_t o,
                               input logic we, input logic [3:0] wa, input rec_t wd,
                               input rec_t wm, input logic [4:0] cfg);
    start = st; clear = cl; valid = v; obs = o;
    gold_we = we; gold_waddr = wa; gold_wdata = wd; gold_wmask = wm; cfg_count = cfg;
    @(posedge clk);
    modelEdge();
    #1;
    start = 1'b0; clear = 1'b0; valid = 1'b0; gold_we = 1'b0;
    checkAll();
  endtask

  task automatic writeEntry(input int idx, input rec_t val, input rec_t mask);
    applyStimulus(0, 0, 0, zeroRec, 1, 4'(idx), val, mask, cfg_count);
  endtask

  task automatic beat(input rec_t o);
    applyStimulus(0, 0, 1, o, 0, 0, zeroRec, zeroRec, cfg_count);
  endtask

  task automatic startRun(input int cfg);
    applyStimulus(1, 0, 0, zeroRec, 0, 0, zeroRec, zeroRec, 5'(cfg));
  endtask

  task automatic clearRun();
    applyStimulus(0, 1, 0, zeroRec, 0, 0, zeroRec, zeroRec, cfg_count);
  endtask

  initial begin
    rec_t e0, badBeat;
    fullMask = '1;
    zeroRec  = '0;
    obs = '0; valid = 0; gold_we = 0; gold_waddr = 0; gold_wdata = '0; gold_wmask = '0;
    cfg_count = 0; start = 0; clear = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mGold[i] = '0; mMask[i] = '0;
    end
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rst = 1'b0;

    // Single literal entry.
    e0.d = 144'h040d0a090200203a01007c414c4943000000;
    e0.t = 16'h9520; e0.a = 17'h0; e0.g = 3'h3; e0.s = 1'b0;
    writeEntry(0, e0, fullMask);
    startRun(1);
    checkOutput("t1_run", 32'(status), 32'd1);
    beat(e0);
    checkOutput("t1_pass", 32'(status), 32'd2);
    checkOutput("t1_beats", 32'(beat_cnt), 32'd1);
    clearRun();

    // Seven back-to-back beats then an overrun.
    for (int i = 0; i < 7; i++) begin
      tbl[i] = randRec();
      writeEntry(i, tbl[i], fullMask);
    end
    startRun(7);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) checkOutput("t2_cur", 32'(cur_idx), 32'(i));
      beat(tbl[i]);
    end
    checkOutput("t2_pass", 32'(status), 32'd2);
    beat(randRec());
    checkOutput("t2_fail", 32'(status), 32'd3);
    checkOutput("t2_over", 32'(overrun), 32'd1);
    checkOutput("t2_fidx", 32'(fail_idx), 32'd6);
    checkOutput("t2_ffld", 32'(fail_fields), 32'd0);
    clearRun();

    // Address mismatch on entry 2; later beats must not disturb the result.
    for (int i = 0; i < 4; i++) begin
      tbl[i] = randRec();
      if (i == 2) tbl[i].a = 17'h0002a;
      writeEntry(i, tbl[i], fullMask);
    end
    startRun(4);
    beat(tbl[0]);
    beat(tbl[1]);
    badBeat = tbl[2];
    badBeat.a = 17'h0002b;
    beat(badBeat);
    checkOutput("t3_fail", 32'(status), 32'd3);
    checkOutput("t3_fidx", 32'(fail_idx), 32'd2);
    checkOutput("t3_ffld", 32'(fail_fields), 32'b00100);
    beat(tbl[3]);
    beat(tbl[0]);
    checkOutput("t3_sticky", 32'(fail_fields), 32'b00100);
    checkOutput("t3_beats", 32'(beat_cnt), 32'd5);
    clearRun();

    // Garbage field masked off.
    tbl[0] = randRec();
    tbl[0].g = 3'h3;
    badBeat = fullMask;
    badBeat.g = 3'h0;
    writeEntry(0, tbl[0], badBeat);
    startRun(2);
    badBeat = tbl[0];
    badBeat.g = 3'h7;
    beat(badBeat);
    checkOutput("t4_cur", 32'(cur_idx), 32'd1);
    checkOutput("t4_run", 32'(status), 32'd1);
    clearRun();

    // Zero count and oversized count.
    startRun(0);
    checkOutput("t5_zero", 32'(status), 32'd2);
    clearRun();
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i] = randRec();
      writeEntry(i, tbl[i], fullMask);
    end
    startRun(31);
    for (int i = 0; i < DEPTH; i++) beat(tbl[i]);
    checkOutput("t5_pass", 32'(status), 32'd2);
    checkOutput("t5_cur", 32'(cur_idx), 32'd15);
    clearRun();

    // Asynchronous reset mid-run, then replay from the retained table.
    startRun(16);
    for (int i = 0; i < 5; i++) beat(tbl[i]);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("t6_async", 32'(status), 32'd0);
    checkAll();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAll();
    startRun(16);
    for (int i = 0; i < DEPTH; i++) beat(tbl[i]);
    checkOutput("t6_replay", 32'(status), 32'd2);

    // Clear wins over start.
    clearRun();
    applyStimulus(1, 1, 0, zeroRec, 0, 0, zeroRec, zeroRec, 5'd3);
    checkOutput("t7_clrstart", 32'(status), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < DEPTH; i++) writeEntry(i, randRec(), fullMask);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int   r;
      int   bit_i;
      logic st, cl, v, we;
      rec_t o, wm;
      logic [4:0] cfg;
      r  = int'($urandom_range(0, 99));
      cl = (r < 3);
      st = (r >= 3 && r < 11) || (r == 1);
      v  = ($urandom_range(0, 9) < 6);
      o  = mGold[mCur];
      if ($urandom_range(0, 4) == 0) begin
        bit_i = int'($urandom_range(0, 180));
        o[bit_i] = ~o[bit_i];
      end
      if ($urandom_range(0, 19) == 0) o = randRec();
      we = ($urandom_range(0, 4) == 0);
      wm = ($urandom_range(0, 1) == 0) ? fullMask : randRec();
      cfg = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 6));
      applyStimulus(st, cl, v, o, we, 4'($urandom_range(0, 15)), randRec(), wm, cfg);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
